// File: rtl/seq_frame_tx.sv
// Serial frame transmitter for the 10110 sync-pattern link: sync pattern, payload MSB-first,
// optional even-parity bit, then idle gap zeros. Every output comes straight from a flop.
module seq_frame_tx #(
  parameter int                DATA_W    = 8,
  parameter int                SYNC_W    = 5,
  parameter logic [SYNC_W-1:0] SYNC_PAT  = 5'b10110,
  parameter int                PARITY_EN = 1,
  parameter int                GAP       = 2
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              outp,
  output logic              out_valid,
  output logic [2:0]        state,
  output logic              done
);

  localparam int MAX_SD = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAX_V  = (MAX_SD > GAP) ? MAX_SD : GAP;
  localparam int CNT_W  = $clog2(MAX_V + 1);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_SYNC = 3'b001,
    S_DATA = 3'b010,
    S_PAR  = 3'b011,
    S_GAP  = 3'b100
  } state_t;

  function automatic logic f_even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  state_t             r_state, w_state_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic               r_ready, w_ready_n;
  logic               r_outp, w_outp_n;
  logic               r_ovld, w_ovld_n;
  logic               r_done, w_done_n;
  logic [DATA_W-1:0]  r_shift, w_shift_n;
  logic [SYNC_W-1:0]  r_sync, w_sync_n;
  logic               r_par, w_par_n;

  // Next-state logic computes the bit to be shown in the following cycle,
  // so outp/out_valid/done/ready can all be plain registers.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_ready_n = 1'b0;
    w_outp_n  = 1'b0;
    w_ovld_n  = 1'b0;
    w_done_n  = 1'b0;
    w_shift_n = r_shift;
    w_sync_n  = r_sync;
    w_par_n   = r_par;
    case (r_state)
      S_IDLE: begin
        w_ready_n = 1'b1;
        if (load && r_ready) begin
          w_state_n = S_SYNC;
          w_cnt_n   = '0;
          w_ready_n = 1'b0;
          w_shift_n = data;
          w_par_n   = f_even_par(data);
          w_sync_n  = SYNC_PAT << 1;
          w_outp_n  = SYNC_PAT[SYNC_W-1];
          w_ovld_n  = 1'b1;
        end
      end
      S_SYNC: begin
        w_ovld_n = 1'b1;
        if (r_cnt == SYNC_LAST) begin
          w_state_n = S_DATA;
          w_cnt_n   = '0;
          w_outp_n  = r_shift[DATA_W-1];
          w_shift_n = r_shift << 1;
        end else begin
          w_cnt_n   = r_cnt + 1'b1;
          w_outp_n  = r_sync[SYNC_W-1];
          w_sync_n  = r_sync << 1;
        end
      end
      S_DATA: begin
        if (r_cnt != DATA_LAST) begin
          w_cnt_n   = r_cnt + 1'b1;
          w_ovld_n  = 1'b1;
          w_outp_n  = r_shift[DATA_W-1];
          w_shift_n = r_shift << 1;
        end else if (PARITY_EN != 0) begin
          w_state_n = S_PAR;
          w_cnt_n   = '0;
          w_ovld_n  = 1'b1;
          w_outp_n  = r_par;
        end else begin
          w_cnt_n  = '0;
          w_done_n = 1'b1;
          if (GAP > 0) begin
            w_state_n = S_GAP;
          end else begin
            w_state_n = S_IDLE;
            w_ready_n = 1'b1;
          end
        end
      end
      S_PAR: begin
        w_cnt_n  = '0;
        w_done_n = 1'b1;
        if (GAP > 0) begin
          w_state_n = S_GAP;
        end else begin
          w_state_n = S_IDLE;
          w_ready_n = 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
          w_ready_n = 1'b1;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
        w_ready_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_outp  <= 1'b0;
      r_ovld  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_ready <= w_ready_n;
      r_outp  <= w_outp_n;
      r_ovld  <= w_ovld_n;
      r_done  <= w_done_n;
    end
  end

  // Payload, remaining sync bits and parity are don't-care after reset.
  always_ff @(posedge CLK) begin
    r_shift <= w_shift_n;
    r_sync  <= w_sync_n;
    r_par   <= w_par_n;
  end

  assign ready     = r_ready;
  assign outp      = r_outp;
  assign out_valid = r_ovld;
  assign done      = r_done;
  assign state     = r_state;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: a default instance (parity, GAP=2) and a PARITY_EN=0/GAP=0 instance,
// checked by a scoreboard of hand-computed frame bits plus a model 10110 detector on outp.
module tb_seq_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, load0, ready0, outp0, ov0, done0;
  logic [7:0] data0;
  logic [2:0] st0;
  logic       rst1, load1, ready1, outp1, ov1, done1;
  logic [7:0] data1;
  logic [2:0] st1;

  seq_frame_tx #(.DATA_W(8), .SYNC_W(5), .SYNC_PAT(5'b10110), .PARITY_EN(1), .GAP(2)) dut (
    .CLK(clk), .rst(rst0), .load(load0), .data(data0), .ready(ready0),
    .outp(outp0), .out_valid(ov0), .state(st0), .done(done0));

  seq_frame_tx #(.DATA_W(8), .SYNC_W(5), .SYNC_PAT(5'b10110), .PARITY_EN(0), .GAP(0)) dut2 (
    .CLK(clk), .rst(rst1), .load(load1), .data(data1), .ready(ready1),
    .outp(outp1), .out_valid(ov1), .state(st1), .done(done1));

  typedef struct packed {logic b; logic se;} exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  logic [4:0] det [2];
  logic prev_ov [2];
  logic prev_rst [2];
  int   n_match [2];

  // Hand-computed frames (sync, payload, parity)
  localparam logic [31:0] FR_A5  = 32'b10110_10100101_0;
  localparam logic [31:0] FR_3C  = 32'b10110_00111100_0;
  localparam logic [31:0] FR_01N = 32'b10110_00000001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int id, input logic [31:0] vec, input int len);
    exp_t e;
    for (int i = len - 1; i >= 0; i--) begin
      e.b  = vec[i];
      e.se = (i == len - 5);
      if (id == 0) q0.push_back(e);
      else         q1.push_back(e);
    end
  endtask

  task automatic mon_step(input int id, input logic ov, input logic ob, input logic dn, input logic r);
    exp_t e;
    logic m;
    int   qs;
    det[id] = {det[id][3:0], ob};
    m = (det[id] == 5'b10110);
    if (m) n_match[id]++;
    if (ov === 1'b1) begin
      qs = (id == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_bit dut%0d: got bit %0b, expected no frame bit at %0t", id, ob, $time);
      end else begin
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        chk($sformatf("bit_dut%0d", id), {31'd0, ob}, {31'd0, e.b});
        chk($sformatf("detect_dut%0d", id), {31'd0, m}, {31'd0, e.se});
      end
    end else begin
      chk($sformatf("idle_outp_dut%0d", id), {31'd0, ob}, 32'd0);
      chk($sformatf("idle_detect_dut%0d", id), {31'd0, m}, 32'd0);
    end
    chk($sformatf("done_dut%0d", id), {31'd0, dn}, {31'd0, prev_ov[id] & ~ov & ~prev_rst[id]});
    prev_ov[id]  = ov;
    prev_rst[id] = r;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_step(0, ov0, outp0, done0, rst0);
      mon_step(1, ov1, outp1, done1, rst1);
    end
  end

  // One frame on dut; busy_cyc/rst_cyc (0 = none) inject a rejected load or a reset.
  task automatic frame0(input logic [7:0] d, input logic [31:0] vec, input int busy_cyc, input int rst_cyc);
    @(posedge clk); #1;
    load0 = 1'b1;
    data0 = d;
    push_frame(0, vec, 14);
    @(posedge clk); #1;
    load0 = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      if (k == busy_cyc) begin
        load0 = 1'b1;
        data0 = 8'hFF;
      end else if (k == busy_cyc + 1) begin
        load0 = 1'b0;
      end
      rst0 = (k == rst_cyc);
      @(negedge clk);
      #1;
      if (k == rst_cyc) q0.delete();
      if (rst_cyc != 0 && k == rst_cyc + 1) begin
        chk("rst_mid_outp", {31'd0, outp0}, 32'd0);
        chk("rst_mid_ovld", {31'd0, ov0}, 32'd0);
        chk("rst_mid_state", {29'd0, st0}, 32'd0);
        chk("rst_mid_ready", {31'd0, ready0}, 32'd1);
      end
      if (rst_cyc == 0) begin
        if (k == 1)  begin chk("f_c1_state", {29'd0, st0}, 32'd1); chk("f_c1_ready", {31'd0, ready0}, 32'd0); end
        if (k == 14) chk("f_c14_ovld", {31'd0, ov0}, 32'd1);
        if (k == 15) begin chk("f_c15_state", {29'd0, st0}, 32'd4); chk("f_c15_done", {31'd0, done0}, 32'd1); end
        if (k == 16) begin chk("f_c16_state", {29'd0, st0}, 32'd4); chk("f_c16_ready", {31'd0, ready0}, 32'd0); end
        if (k == 17) begin chk("f_c17_state", {29'd0, st0}, 32'd0); chk("f_c17_ready", {31'd0, ready0}, 32'd1); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int m_before, acc, last_v, dn;
    logic pv, drop, fin;
    det[0] = '0; det[1] = '0;
    prev_ov[0] = 1'b0; prev_ov[1] = 1'b0;
    prev_rst[0] = 1'b1; prev_rst[1] = 1'b1;
    n_match[0] = 0; n_match[1] = 0;
    rst0 = 1'b1; load0 = 1'b1; data0 = 8'hA5;
    rst1 = 1'b1; load1 = 1'b1; data1 = 8'h01;

    // Reset held 2 cycles with load asserted
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0; load0 = 1'b0;
    rst1 = 1'b0; load1 = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready0}, 32'd1);
    chk("rst_outp", {31'd0, outp0}, 32'd0);
    chk("rst_ovld", {31'd0, ov0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_state", {29'd0, st0}, 32'd0);
    chk("rst2_ready", {31'd0, ready1}, 32'd1);
    repeat (2) @(negedge clk);
    chk("rst_no_frame_state", {29'd0, st0}, 32'd0);
    chk("rst_no_frame_ovld", {31'd0, ov0}, 32'd0);

    frame0(8'hA5, FR_A5, 0, 0);
    frame0(8'hA5, FR_A5, 3, 0);
    frame0(8'hA5, FR_A5, 0, 9);
    frame0(8'h3C, FR_3C, 0, 0);

    m_before = n_match[0];
    repeat (3) frame0(8'hA5, FR_A5, 0, 0);
    chk("loopback_matches", n_match[0] - m_before, 32'd3);

    // PARITY_EN=0, GAP=0 with load held high for three frames
    repeat (3) push_frame(1, FR_01N, 13);
    @(posedge clk); #1;
    load1 = 1'b1;
    data1 = 8'h01;
    acc = 0; last_v = -1; dn = 0; pv = 1'b0; drop = 1'b0; fin = 1'b0;
    for (int c = 0; c < 80 && !fin; c++) begin
      @(negedge clk);
      #1;
      if (ready1 && load1) begin
        acc++;
        if (acc == 3) drop = 1'b1;
      end
      if (done1) begin
        dn++;
        chk("dut2_done_in_idle", {29'd0, st1}, 32'd0);
      end
      if (ov1 && !pv && last_v >= 0) chk("dut2_spacing", c - last_v, 32'd2);
      if (ov1) last_v = c;
      pv = ov1;
      if (dn == 3) fin = 1'b1;
      @(posedge clk); #1;
      if (drop) load1 = 1'b0;
    end
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL dut2_timeout: got %0d done pulses, expected 3", dn);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
